audio_rom_write: RTL and testbench

AUDIO_ROM_WRITE -- requirements
Module: audio_rom_write

---
 rtl/audio_rom_write.sv | 268 ++++++++++++++++++++++++++
 tb/tb_audio_rom_write.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_rom_write.sv
// audio_rom_write
//   Streams 16-bit audio samples into a SPI NOR flash, one 256-byte page
//   at a time, over an inclusive page range.
//   Flow: every page whose low 4 bits are zero is sector-erased first
//   (WREN, ERASE 0x20, RDSR poll); then every page is programmed
//   (WREN, PP 0x02 + address, 128 words as 256 bytes, RDSR poll).
//
// Ports
//   iSCLK / iSRST        system clock, asynchronous active-high reset
//   oSfmSck/oSfmMosi     SPI mode-0 clock and data out (MSB first)
//   iSfmMiso             SPI data in
//   oSfmCs               flash chip select, active low
//   iWd/iWvd/oWrdy       sample stream; a word moves when iWvd & oWrdy
//   iSfmEn               rising edge starts a job
//   iSfmDiv              SCK half-period is iSfmDiv+1 clocks
//   iSfmCsHoldTime       minimum CS-high gap in clocks (0 behaves as 1)
//   iSfmStartAdrs/EndAdrs first/last page, inclusive
//   oSfmBusy / oSfmDone  job active level / one-cycle end-of-job pulse
module audio_rom_write #(
  parameter int pSfmPageWidth = 16
) (
  input  logic                     iSCLK,
  input  logic                     iSRST,
  output logic                     oSfmSck,
  output logic                     oSfmMosi,
  input  logic                     iSfmMiso,
  output logic                     oSfmCs,
  input  logic [15:0]              iWd,
  input  logic                     iWvd,
  output logic                     oWrdy,
  input  logic                     iSfmEn,
  input  logic [7:0]               iSfmDiv,
  input  logic [7:0]               iSfmCsHoldTime,
  input  logic [pSfmPageWidth-1:0] iSfmStartAdrs,
  input  logic [pSfmPageWidth-1:0] iSfmEndAdrs,
  output logic                     oSfmBusy,
  output logic                     oSfmDone
);

  typedef enum logic [3:0] {
    IDLE, WREN, GAP, ERASE, POLL, PROG_HDR, PROG_DATA, NEXT, DONE
  } state_t;

  state_t                   state_q, ret_q;
  logic [pSfmPageWidth-1:0] page_q, end_q;
  logic [7:0]               div_q, hold_q, gap_q, step_q;
  logic [7:0]               tx_q, hi_q, cnt_q;
  logic [2:0]               bit_q;
  logic                     empty_q, prog_phase_q, en_q, xfer_q, miso_q;
  logic                     sck_q, mosi_q, cs_q, wrdy_q, busy_q, done_q;

  logic [pSfmPageWidth+7:0] adr_full;
  logic [23:0]              adr;
  logic [pSfmPageWidth-1:0] page_inc;
  logic [7:0]               gap_init, hdr_byte, load_val_d;
  logic                     byte_end, load_d;

  assign adr_full = {page_q, 8'h00};
  assign adr      = 24'(adr_full);
  assign page_inc = page_q + pSfmPageWidth'(1);
  assign gap_init = (hold_q == 8'd0) ? 8'd1 : hold_q;
  // Last falling SCK edge of a byte: SCK returns low here, so this is the
  // only point where CS may be released.
  assign byte_end = xfer_q && (cnt_q == 8'd0) && sck_q && (bit_q == 3'd7);

  // Command / address byte for the current state and byte index.
  always_comb begin
    hdr_byte = 8'h00;
    if (step_q == 8'd0) begin
      case (state_q)
        ERASE:    hdr_byte = 8'h20;
        PROG_HDR: hdr_byte = 8'h02;
        POLL:     hdr_byte = 8'h05;
        default:  hdr_byte = 8'h06;
      endcase
    end else if (state_q != POLL) begin
      case (step_q[1:0])
        2'd1:    hdr_byte = adr[23:16];
        2'd2:    hdr_byte = adr[15:8];
        2'd3:    hdr_byte = adr[7:0];
        default: hdr_byte = 8'h00;
      endcase
    end
  end

  // Decide whether a new byte starts this cycle (only when the shifter is idle).
  always_comb begin
    load_d     = 1'b0;
    load_val_d = hdr_byte;
    if (!xfer_q) begin
      case (state_q)
        WREN:                  load_d = !empty_q;
        ERASE, PROG_HDR, POLL: load_d = 1'b1;
        PROG_DATA: begin
          if (step_q[0]) begin
            load_d     = 1'b1;
            load_val_d = hi_q;
          end else if (wrdy_q && iWvd) begin
            load_d     = 1'b1;
            load_val_d = iWd[7:0];
          end
        end
        default: load_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge iSCLK or posedge iSRST) begin
    if (iSRST) begin
      state_q <= IDLE;  ret_q <= IDLE;
      page_q <= '0;     end_q <= '0;
      div_q <= '0;      hold_q <= '0;  gap_q <= '0;  step_q <= '0;
      tx_q <= '0;       hi_q <= '0;    cnt_q <= '0;  bit_q <= '0;
      empty_q <= 1'b0;  prog_phase_q <= 1'b0; en_q <= 1'b0;
      xfer_q <= 1'b0;   miso_q <= 1'b0;
      sck_q <= 1'b0;    mosi_q <= 1'b0; cs_q <= 1'b1;
      wrdy_q <= 1'b0;   busy_q <= 1'b0; done_q <= 1'b0;
    end else begin
      en_q   <= iSfmEn;
      done_q <= 1'b0;

      // Byte shifter: SCK toggles every div+1 clocks; MOSI changes after
      // each falling edge, MISO is captured with each rising edge.
      if (xfer_q) begin
        if (cnt_q != 8'd0) begin
          cnt_q <= cnt_q - 8'd1;
        end else begin
          cnt_q <= div_q;
          if (!sck_q) begin
            sck_q  <= 1'b1;
            miso_q <= iSfmMiso;
          end else begin
            sck_q <= 1'b0;
            if (bit_q == 3'd7) begin
              xfer_q <= 1'b0;
            end else begin
              bit_q  <= bit_q + 3'd1;
              tx_q   <= {tx_q[6:0], 1'b0};
              mosi_q <= tx_q[6];
            end
          end
        end
      end
      if (load_d) begin
        xfer_q <= 1'b1;
        tx_q   <= load_val_d;
        mosi_q <= load_val_d[7];
        bit_q  <= 3'd0;
        cnt_q  <= div_q;
        cs_q   <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          // done_q high means the done pulse is on the pins this cycle.
          if (iSfmEn && !en_q && !done_q) begin
            page_q       <= iSfmStartAdrs;
            end_q        <= iSfmEndAdrs;
            empty_q      <= iSfmStartAdrs > iSfmEndAdrs;
            div_q        <= iSfmDiv;
            hold_q       <= iSfmCsHoldTime;
            prog_phase_q <= iSfmStartAdrs[3:0] != 4'd0;
            step_q       <= 8'd0;
            busy_q       <= 1'b1;
            state_q      <= WREN;
          end
        end
        WREN: begin
          if (empty_q) begin
            state_q <= DONE;
          end else if (byte_end) begin
            cs_q    <= 1'b1;
            gap_q   <= gap_init;
            ret_q   <= prog_phase_q ? PROG_HDR : ERASE;
            state_q <= GAP;
          end
        end
        GAP: begin
          if (gap_q <= 8'd1) begin
            step_q  <= 8'd0;
            state_q <= ret_q;
          end else begin
            gap_q <= gap_q - 8'd1;
          end
        end
        ERASE: begin
          if (byte_end) begin
            if (step_q == 8'd3) begin
              cs_q    <= 1'b1;
              gap_q   <= gap_init;
              ret_q   <= POLL;
              state_q <= GAP;
            end else begin
              step_q <= step_q + 8'd1;
            end
          end
        end
        PROG_HDR: begin
          if (byte_end) begin
            if (step_q == 8'd3) begin
              step_q  <= 8'd0;
              state_q <= PROG_DATA;
            end else begin
              step_q <= step_q + 8'd1;
            end
          end
        end
        PROG_DATA: begin
          // Even byte index needs a fresh word; its high byte is parked in hi_q.
          if (load_d && !step_q[0]) begin
            hi_q   <= iWd[15:8];
            wrdy_q <= 1'b0;
          end else if (!xfer_q && !step_q[0]) begin
            wrdy_q <= 1'b1;
          end
          if (byte_end) begin
            if (step_q == 8'd255) begin
              cs_q    <= 1'b1;
              gap_q   <= gap_init;
              ret_q   <= POLL;
              state_q <= GAP;
            end else begin
              step_q <= step_q + 8'd1;
            end
          end
        end
        POLL: begin
          // miso_q holds the last bit shifted in, i.e. status bit0 (WIP).
          if (byte_end) begin
            if (step_q != 8'd0 && !miso_q) begin
              cs_q         <= 1'b1;
              gap_q        <= gap_init;
              ret_q        <= prog_phase_q ? NEXT : WREN;
              prog_phase_q <= 1'b1;
              state_q      <= GAP;
            end else begin
              step_q <= 8'd1;
            end
          end
        end
        NEXT: begin
          if (page_q == end_q) begin
            state_q <= DONE;
          end else begin
            page_q       <= page_inc;
            prog_phase_q <= page_inc[3:0] != 4'd0;
            step_q       <= 8'd0;
            state_q      <= WREN;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oSfmSck  = sck_q;
  assign oSfmMosi = mosi_q;
  assign oSfmCs   = cs_q;
  assign oWrdy    = wrdy_q;
  assign oSfmBusy = busy_q;
  assign oSfmDone = done_q;

endmodule

// File: tb/tb_audio_rom_write.sv
// Randomised scoreboard bench for audio_rom_write.
// Expected SPI frames are built from the page/erase/program rules when a job
// is issued; a bus monitor decodes MOSI bytes and CS frames and checks them
// against the queue. A small flash model answers RDSR with WIP=1 for a
// chosen number of status bytes.
module tb_audio_rom_write;

  localparam int CS_MARK = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sck, mosi, miso, cs, wrdy, busy, done;
  logic [15:0] wd = 16'h0;
  logic        wvd = 1'b0;
  logic        en = 1'b0;
  logic [7:0]  div = 8'd0, hold = 8'd0;
  logic [15:0] start_adr = 16'h0, end_adr = 16'h0;

  always #5 clk = ~clk;

  audio_rom_write #(.pSfmPageWidth(16)) dut (
    .iSCLK(clk), .iSRST(rst),
    .oSfmSck(sck), .oSfmMosi(mosi), .iSfmMiso(miso), .oSfmCs(cs),
    .iWd(wd), .iWvd(wvd), .oWrdy(wrdy),
    .iSfmEn(en), .iSfmDiv(div), .iSfmCsHoldTime(hold),
    .iSfmStartAdrs(start_adr), .iSfmEndAdrs(end_adr),
    .oSfmBusy(busy), .oSfmDone(done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard queues
  int          exp_q[$];   // bytes 0..255, CS_MARK = CS rising edge
  int          wip_q[$];   // WIP=1 status bytes for each RDSR frame
  logic [15:0] word_q[$];  // samples still to be offered to the DUT

  function automatic int pop_exp();
    if (exp_q.size() == 0) return -1;
    return exp_q.pop_front();
  endfunction

  task automatic push_poll(input int wip_fix);
    int n;
    n = (wip_fix >= 0) ? wip_fix : int'($urandom_range(0, 3));
    exp_q.push_back(8'h05);
    for (int i = 0; i <= n; i++) exp_q.push_back(8'h00);
    exp_q.push_back(CS_MARK);
    wip_q.push_back(n);
  endtask

  // Reference model of one job: returns number of programmed pages.
  task automatic build_job(input logic [15:0] s, input logic [15:0] e,
                           input int wip_fix, input bit special, output int pages);
    logic [15:0] p;
    logic [15:0] w;
    pages = 0;
    if (s > e) return;
    p = s;
    forever begin
      if (p[3:0] == 4'h0) begin
        exp_q.push_back(8'h06); exp_q.push_back(CS_MARK);
        exp_q.push_back(8'h20); exp_q.push_back(int'(p[15:8]));
        exp_q.push_back(int'(p[7:0])); exp_q.push_back(8'h00);
        exp_q.push_back(CS_MARK);
        push_poll(wip_fix);
      end
      exp_q.push_back(8'h06); exp_q.push_back(CS_MARK);
      exp_q.push_back(8'h02); exp_q.push_back(int'(p[15:8]));
      exp_q.push_back(int'(p[7:0])); exp_q.push_back(8'h00);
      for (int i = 0; i < 128; i++) begin
        if (special && pages == 0 && i == 0)      w = 16'hA55A;
        else if (special && pages == 0 && i == 1) w = 16'h1234;
        else                                      w = 16'($urandom);
        word_q.push_back(w);
        exp_q.push_back(int'(w[7:0]));
        exp_q.push_back(int'(w[15:8]));
      end
      exp_q.push_back(CS_MARK);
      push_poll(wip_fix);
      pages++;
      if (p == e) break;
      p = p + 16'd1;
    end
  endtask

  // ---------------- bus monitor + flash status model ----------------
  bit   mon_off  = 1'b0;
  logic prev_sck = 1'b0;
  logic prev_cs  = 1'b1;
  int   bitcnt   = 0;
  logic [7:0] sh = 8'h00;
  bit   rdsr     = 1'b0;
  int   wip_n    = 0;
  int   mon_e;

  // Status bit0 is the 8th bit of each status byte; WIP=1 for the first wip_n.
  assign miso = rdsr && (bitcnt % 8 == 7) && ((bitcnt / 8 - 1) < wip_n);

  always @(negedge clk) begin
    if (mon_off) begin
      prev_sck = 1'b0; prev_cs = 1'b1; bitcnt = 0; rdsr = 1'b0;
    end else begin
      if (!cs && sck && !prev_sck) begin
        sh = {sh[6:0], mosi};
        bitcnt++;
        if (bitcnt % 8 == 0) begin
          mon_e = pop_exp();
          check("mosi_byte", {24'h0, sh}, mon_e);
          if (bitcnt == 8 && sh == 8'h05) begin
            rdsr  = 1'b1;
            wip_n = (wip_q.size() > 0) ? wip_q.pop_front() : 0;
          end
        end
      end
      if (cs && !prev_cs) begin
        check("cs_on_byte_boundary", bitcnt % 8, 0);
        check("sck_low_at_cs_rise", sck, 0);
        mon_e = pop_exp();
        check("frame_end", mon_e, CS_MARK);
        bitcnt = 0;
        rdsr   = 1'b0;
      end
      prev_sck = sck;
      prev_cs  = cs;
    end
  end

  // ---------------- done monitor ----------------
  int done_cnt = 0;
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      check("busy_low_with_done", busy, 0);
    end
  end

  // ---------------- sample source ----------------
  bit pend_hs    = 1'b0;
  int hs_cnt     = 0;
  int stall_at   = -1;
  int stall_left = 0;

  always @(negedge clk) begin
    if (pend_hs) begin
      if (word_q.size() > 0) void'(word_q.pop_front());
      hs_cnt++;
    end
    if (rst) begin
      wvd     = 1'b0;
      pend_hs = 1'b0;
    end else begin
      if (stall_left > 0) begin
        wvd = 1'b0;
        stall_left--;
        if (stall_left == 0) begin
          check("stall_cs_low", cs, 0);
          check("stall_sck_low", sck, 0);
          check("stall_wrdy_held", wrdy, 1);
        end
      end else if (stall_at >= 0 && hs_cnt >= stall_at && wrdy) begin
        stall_at   = -1;
        stall_left = 50;
        wvd        = 1'b0;
      end else if (word_q.size() > 0 && $urandom_range(0, 4) != 0) begin
        wvd = 1'b1;
        wd  = word_q[0];
      end else begin
        wvd = 1'b0;
      end
      pend_hs = wvd && wrdy;
    end
  end

  // ---------------- job driver ----------------
  task automatic run_job(input logic [15:0] s, input logic [15:0] e,
                         input logic [7:0] d, input logic [7:0] h,
                         input int wip_fix, input bit special, input bit do_stall);
    int pages, hs0, d0, lim;
    build_job(s, e, wip_fix, special, pages);
    hs0 = hs_cnt;
    d0  = done_cnt;
    if (do_stall) stall_at = hs_cnt + 40;
    @(negedge clk);
    start_adr = s; end_adr = e; div = d; hold = h; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    check("busy_after_start", busy, 1);
    // Inputs changed while busy must not affect the running job.
    start_adr = 16'($urandom); end_adr = 16'($urandom);
    div = 8'($urandom_range(0, 3)); hold = 8'($urandom);
    repeat (40) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    lim = pages * 20000 + 200;
    for (int i = 0; i < lim && done_cnt == d0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    check("done_pulses", done_cnt - d0, 1);
    check("bytes_left", exp_q.size(), 0);
    check("handshakes", hs_cnt - hs0, pages * 128);
    check("polls_left", wip_q.size(), 0);
    check("busy_after_done", busy, 0);
    stall_at = -1;
  endtask

  initial begin
    int pages, hs0, d0;
    #1 rst = 1'b1;
    #2;
    check("rst_cs", cs, 1);
    check("rst_sck", sck, 0);
    check("rst_mosi", mosi, 0);
    check("rst_wrdy", wrdy, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single erase+program page, fixed 3 busy polls each.
    run_job(16'h0010, 16'h0010, 8'd0, 8'($urandom_range(0, 3)), 3, 1'b0, 1'b0);
    // Two program-only pages, known first words, 50-cycle source stall.
    run_job(16'h0011, 16'h0012, 8'($urandom_range(0, 1)), 8'd0, -1, 1'b1, 1'b1);

    // Empty range: done two cycles after the start edge, CS never asserted.
    @(negedge clk);
    start_adr = 16'd5; end_adr = 16'd3; div = 8'd0; hold = 8'd1; en = 1'b1;
    d0 = done_cnt;
    @(negedge clk);
    en = 1'b0;
    check("empty_busy_k", busy, 1);
    check("empty_done_k", done, 0);
    check("empty_cs_k", cs, 1);
    @(negedge clk);
    check("empty_done_k1", done, 0);
    check("empty_cs_k1", cs, 1);
    @(negedge clk);
    check("empty_done_k2", done, 1);
    check("empty_busy_k2", busy, 0);
    check("empty_cs_k2", cs, 1);
    @(negedge clk);
    check("empty_done_k3", done, 0);
    check("empty_done_count", done_cnt - d0, 1);

    // Reset in the middle of page data.
    build_job(16'h0020, 16'h0020, -1, 1'b0, pages);
    hs0 = hs_cnt;
    d0  = done_cnt;
    @(negedge clk);
    start_adr = 16'h0020; end_adr = 16'h0020; div = 8'd0; hold = 8'd2; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 30000 && (hs_cnt - hs0) < 20; i++) @(negedge clk);
    check("reached_prog_data", ((hs_cnt - hs0) >= 20) ? 1 : 0, 1);
    @(posedge clk);
    #1;
    mon_off = 1'b1;
    rst = 1'b1;
    #1;
    check("midrst_cs", cs, 1);
    check("midrst_sck", sck, 0);
    check("midrst_wrdy", wrdy, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    repeat (3) @(negedge clk);
    exp_q.delete();
    word_q.delete();
    wip_q.delete();
    rst = 1'b0;
    mon_off = 1'b0;
    repeat (10) @(negedge clk);
    check("no_done_after_reset", done_cnt - d0, 0);

    // Fresh job after the reset: program-only page then an erase page.
    run_job(16'h002F, 16'h0030, 8'd1, 8'd5, -1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
